// File: rtl/dmem_wb_bridge.sv
// dmem_wb_bridge
//   Turns one MEM-stage load/store request from the rv32i core into a single
//   Wishbone B4 classic master cycle. It stalls the pipeline until that cycle
//   terminates. It also generates the byte lanes, aligns store data and
//   extracts/extends load data.
//
// State table
//   state | meaning
//   IDLE  | waiting for mem_read_i/mem_write_i; request latched into bus regs
//   BUS   | Wishbone cycle open (cyc/stb high), waiting for ack/err/timeout
//   DONE  | one-cycle completion: mem_ack_o plus optional err/misaligned pulse
//
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   mem_addr_i/wdata_i       byte address and right-aligned store data
//   mem_write_i/read_i/op_i  request strobes and funct3 access code
//   mem_rdata_o              extended load result, held until next DONE
//   mem_ack_o, stall_o       completion pulse, pipeline stall (combinational)
//   bus_err_o, misaligned_o  one-cycle status pulses, coincident with ack
//   wb_*                     Wishbone B4 classic master port (registered)
module dmem_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    input  logic [2:0]  mem_op_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misaligned_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        req;
    logic        timeout;
    logic        lane_mis;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req     = mem_read_i | mem_write_i;
    assign timeout = (cnt_q == CNT_LAST);

    // Request-side lane generation; undefined op codes fall into the word case.
    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = mem_wdata_i;
        lane_mis   = |mem_addr_i[1:0];
        case (mem_op_i)
            3'b000, 3'b100: begin
                lane_sel   = 4'b0001 << mem_addr_i[1:0];
                lane_wdata = {4{mem_wdata_i[7:0]}};
                lane_mis   = 1'b0;
            end
            3'b001, 3'b101: begin
                lane_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{mem_wdata_i[15:0]}};
                lane_mis   = mem_addr_i[0];
            end
            default: ;
        endcase
    end

    // Load extraction works from the latched op/offset, because the core's
    // request inputs are not guaranteed stable once the bus cycle is open.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = wb_dat_i[7:0];
            2'd1:    ld_byte = wb_dat_i[15:8];
            2'd2:    ld_byte = wb_dat_i[23:16];
            default: ld_byte = wb_dat_i[31:24];
        endcase
        ld_half = off_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        case (op_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = wb_dat_i;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = lane_mis ? ST_DONE : ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_err_i || wb_ack_i || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        op_d    = op_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (lane_mis) begin
                        ack_d   = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        cyc_d = 1'b1;
                        we_d  = mem_write_i;
                        adr_d = {mem_addr_i[31:2], 2'b00};
                        dat_d = lane_wdata;
                        sel_d = lane_sel;
                        op_d  = mem_op_i;
                        off_d = mem_addr_i[1:0];
                        cnt_d = 16'd0;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 16'd1;
                // err wins over a simultaneous ack; an ack in the last
                // allowed cycle wins over the timeout.
                if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? 32'd0 : load_data;
                end else if (timeout) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            op_q    <= 3'd0;
            off_q   <= 2'd0;
            cnt_q   <= 16'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Output logic; stall is the only output with a combinational input path.
    always_comb begin
        stall_o = ((state_q == ST_IDLE) && req) || (state_q == ST_BUS);
    end

    assign mem_rdata_o  = rdata_q;
    assign mem_ack_o    = ack_q;
    assign bus_err_o    = err_q;
    assign misaligned_o = mis_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
module tb_dmem_wb_bridge;

    localparam int TO = 4;
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_BOTH = 3;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        mem_write_i, mem_read_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o, stall_o, bus_err_o, misaligned_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    dmem_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_write_i(mem_write_i), .mem_read_i(mem_read_i), .mem_op_i(mem_op_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .stall_o(stall_o),
        .bus_err_o(bus_err_o), .misaligned_o(misaligned_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          stall;
    } resp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          mode;
        int          waits;
        logic [31:0] word;
        int          ncyc;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    stray_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] op, input int off,
                                               input logic [31:0] word);
        int          sz;
        logic [31:0] v, mask;
        sz = acc_size(op);
        v  = word >> (8 * off);
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v    = v & mask;
            if ((op == 3'd0 || op == 3'd1) && v > (mask >> 1))
                v = v | ~mask;
        end
        return v;
    endfunction

    // Issue one request, push its expectations, wait for completion.
    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic wr, input logic rd, input int mode, input int waits,
                          input logic [31:0] word);
        int    sz, off;
        bit    mis, got;
        resp_t r;
        bus_t  b;
        sz  = acc_size(op);
        off = int'(addr[1:0]);
        mis = (off % sz) != 0;
        if (mis) begin
            r = '{rdata: 32'd0, err: 1'b0, mis: 1'b1, stall: 1};
        end else begin
            b.adr   = addr & ~32'h3;
            b.we    = wr;
            b.sel   = 4'(((1 << sz) - 1) << off);
            b.dat   = (sz == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
                      (sz == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
            b.mode  = mode;
            b.waits = waits;
            b.word  = word;
            r.mis   = 1'b0;
            if (mode == M_NONE) begin
                r.err = 1'b1; r.rdata = 32'd0; r.stall = TO + 1; b.ncyc = TO;
            end else if (mode == M_ACK) begin
                r.err = 1'b0; r.rdata = wr ? 32'd0 : load_model(op, off, word);
                r.stall = waits + 2; b.ncyc = waits + 1;
            end else begin
                r.err = 1'b1; r.rdata = 32'd0; r.stall = waits + 2; b.ncyc = waits + 1;
            end
            bus_q.push_back(b);
        end
        resp_q.push_back(r);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_write_i = wr;
        mem_read_i  = rd;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (mem_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL ack_wait: got no mem_ack_o expected one within 100 cycles");
        end
        @(posedge clk_i); #1;
        mem_write_i = 1'b0;
        mem_read_i  = 1'b0;
    endtask

    // Slave model and bus-side checker
    initial begin : slave
        bus_t cur;
        bit   in_cyc, cur_ok;
        int   ncyc;
        in_cyc = 1'b0; cur_ok = 1'b0; ncyc = 0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'd0;
        forever begin
            @(negedge clk_i);
            if (wb_cyc_o === 1'b1) begin
                if (!in_cyc) begin
                    ncyc = 0;
                    if (bus_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_cyc: got wb_cyc_o=1 expected 0 at %0t", $time);
                        cur_ok = 1'b0;
                    end else begin
                        cur    = bus_q.pop_front();
                        cur_ok = 1'b1;
                    end
                    in_cyc = 1'b1;
                end
                if (cur_ok) begin
                    chk("wb_adr", wb_adr_o, cur.adr);
                    chk("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
                    chk("wb_we", 32'(wb_we_o), 32'(cur.we));
                    chk("wb_stb", 32'(wb_stb_o), 32'd1);
                    if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
                end
                wb_ack_i = cur_ok && (cur.mode == M_ACK || cur.mode == M_BOTH) && ncyc == cur.waits;
                wb_err_i = cur_ok && (cur.mode == M_ERR || cur.mode == M_BOTH) && ncyc == cur.waits;
                wb_dat_i = cur_ok ? cur.word : $urandom;
                ncyc++;
            end else begin
                if (in_cyc) begin
                    if (cur_ok && cur.ncyc >= 0) chk("cyc_len", 32'(ncyc), 32'(cur.ncyc));
                    in_cyc = 1'b0;
                end
                wb_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
        end
    end

    // Core-side monitor / scoreboard
    initial begin : monitor
        resp_t       r;
        int          stall_cnt;
        logic [31:0] last_rdata;
        stall_cnt = 0; last_rdata = 32'd0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                stall_cnt  = 0;
                last_rdata = 32'd0;
            end else begin
                if (stall_o) stall_cnt++;
                if (mem_ack_o) begin
                    if (resp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_ack: got mem_ack_o=1 expected 0 at %0t", $time);
                    end else begin
                        r = resp_q.pop_front();
                        chk("rdata", mem_rdata_o, r.rdata);
                        chk("bus_err", 32'(bus_err_o), 32'(r.err));
                        chk("misaligned", 32'(misaligned_o), 32'(r.mis));
                        chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
                        last_rdata = r.rdata;
                    end
                    stall_cnt = 0;
                end else begin
                    chk("err_idle", 32'(bus_err_o), 32'd0);
                    chk("mis_idle", 32'(misaligned_o), 32'd0);
                    chk("rdata_hold", mem_rdata_o, last_rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus_t b;
        bit   seen;
        int   kind, mr;
        logic [2:0] op;
        reset_i = 1'b1;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0; mem_op_i = 3'd0;
        mem_write_i = 1'b0; mem_read_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ack", 32'(mem_ack_o), 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        access(3'b010, 32'h100, 32'd0, 1'b0, 1'b1, M_ACK, 2, 32'hDEADBEEF);
        access(3'b000, 32'h103, 32'd0, 1'b0, 1'b1, M_ACK, 0, 32'h80F17F00);
        access(3'b100, 32'h103, 32'd0, 1'b0, 1'b1, M_ACK, 1, 32'h80F17F00);
        access(3'b001, 32'h102, 32'd0, 1'b0, 1'b1, M_ACK, 0, 32'h80F17F00);
        access(3'b101, 32'h102, 32'd0, 1'b0, 1'b1, M_ACK, 3, 32'h80F17F00);
        access(3'b000, 32'h201, 32'h12345678, 1'b1, 1'b0, M_ACK, 0, 32'h0);
        access(3'b001, 32'h202, 32'h12345678, 1'b1, 1'b0, M_ACK, 1, 32'h0);
        access(3'b010, 32'h102, 32'd0, 1'b0, 1'b1, M_ACK, 0, 32'h0);
        access(3'b001, 32'h101, 32'h5555AAAA, 1'b1, 1'b0, M_ACK, 0, 32'h0);
        access(3'b010, 32'h400, 32'd0, 1'b0, 1'b1, M_NONE, 0, 32'h0);
        access(3'b010, 32'h404, 32'd0, 1'b0, 1'b1, M_ERR, 0, 32'h0);
        access(3'b010, 32'h408, 32'd0, 1'b0, 1'b1, M_BOTH, 1, 32'h11111111);
        access(3'b010, 32'h40C, 32'hCAFEF00D, 1'b1, 1'b1, M_ACK, 0, 32'h22222222);

        // Reset in the middle of a bus cycle
        b = '{adr: 32'h300, dat: 32'd0, sel: 4'hF, we: 1'b0, mode: M_NONE,
              waits: 0, word: 32'd0, ncyc: -1};
        bus_q.push_back(b);
        mem_op_i = 3'b010; mem_addr_i = 32'h300; mem_read_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (wb_cyc_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_cyc_seen", 32'(seen), 32'd1);
        @(posedge clk_i); #1;
        reset_i = 1'b1; mem_read_i = 1'b0;
        @(posedge clk_i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
            chk("midrst_stb", 32'(wb_stb_o), 32'd0);
            chk("midrst_stall", 32'(stall_o), 32'd0);
            chk("midrst_ack", 32'(mem_ack_o), 32'd0);
            chk("midrst_adr", wb_adr_o, 32'd0);
            chk("midrst_sel", 32'(wb_sel_o), 32'd0);
            chk("midrst_rdata", mem_rdata_o, 32'd0);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        access(3'b010, 32'h500, 32'h0BADCAFE, 1'b1, 1'b0, M_ACK, 1, 32'h0);

        // Randomized traffic with stray acks outside BUS
        for (int t = 0; t < 150; t++) begin
            stray_en = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            mr   = $urandom_range(0, 9);
            access(op, $urandom, $urandom, kind != 0, kind != 1,
                   (mr < 6) ? M_ACK : (mr < 8) ? M_ERR : (mr < 9) ? M_BOTH : M_NONE,
                   $urandom_range(0, TO - 1), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end
        stray_en = 1'b0;

        repeat (5) @(negedge clk_i);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
